// File: rtl/sram_arbiter_pkg.sv
// Shared types and helpers for the SRAM arbiter.
// Used by sram_arbiter and rr_pick.
package sram_arb_pkg;

    // Upper bound on the number of requesters this arbiter is meant for
    localparam int MAX_MASTER = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    // Width of a master index (at least one bit, even for two masters)
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// rr_pick: rotating priority encoder.
// It scans the request vector starting at start_i in circular order.
// It returns the first requester as a one-hot grant and as an index.
module rr_pick
    import sram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]        req_i,
    input  logic [idx_w(N)-1:0] start_i,
    output logic [N-1:0]        gnt_o,
    output logic [idx_w(N)-1:0] idx_o,
    output logic                valid_o
);

    localparam int IW = idx_w(N);

    // Scan from the start pointer and keep the first requester found
    always_comb begin
        int  pos;
        logic found;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(start_i) + k) % N;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = IW'(pos);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter that shares one single-port SRAM slave.
// Grants are zero-cycle. Read data is broadcast and flagged with a one-hot rvalid.
// A bounded lock lets one master keep the slave for read-modify-write sequences.
// Optional macro SRAM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int LEN_ADDR = 64,
    parameter int LEN_DATA = 64,
    parameter int N_MASTER = 2,
    parameter int LOCK_MAX = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [N_MASTER-1:0]            m_req_i,
    input  logic [N_MASTER-1:0]            m_lock_i,
    input  logic [N_MASTER*LEN_ADDR-1:0]   m_addra_i,
    input  logic [N_MASTER*LEN_DATA-1:0]   m_dina_i,
    input  logic [N_MASTER*LEN_DATA/8-1:0] m_wea_i,
    output logic [N_MASTER-1:0]            m_gnt_o,
    output logic [LEN_DATA-1:0]            m_douta_o,
    output logic [N_MASTER-1:0]            m_rvalid_o,
    output logic [LEN_ADDR-1:0]            s_addra_o,
    output logic [LEN_DATA-1:0]            s_dina_o,
    input  logic [LEN_DATA-1:0]            s_douta_i,
    output logic                           s_ena_o,
    output logic [LEN_DATA/8-1:0]          s_wea_o
);

    localparam int IW = idx_w(N_MASTER);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam int NB = LEN_DATA / 8;

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [CW-1:0]       lockCnt_q, lockCnt_d;
    logic [N_MASTER-1:0] rdPend_q, rdPend_d;
    logic [IW-1:0]       startPtr;

    logic                ownerHold;
    logic [N_MASTER-1:0] effReq;
    logic [N_MASTER-1:0] pickGnt;
    logic [IW-1:0]       pickIdx;
    logic                pickValid;
    logic                isRead;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign startPtr = '0;
`else
    logic [IW-1:0] rrPtr_q, rrPtr_d;
    assign startPtr = rrPtr_q;
`endif

    // A locked owner that is still requesting shuts everyone else out.
    // Once it drops req, the same cycle arbitrates normally.
    assign ownerHold = (state_q == ARB_LOCKED) && m_req_i[owner_q];

    // Requests the picker may consider; nothing is granted while in reset
    always_comb begin
        effReq = '0;
        if (rst_i) begin
            effReq = '0;
        end else if (ownerHold) begin
            effReq[owner_q] = 1'b1;
        end else begin
            effReq = m_req_i;
        end
    end

    rr_pick #(
        .N(N_MASTER)
    ) u_pick (
        .req_i   (effReq),
        .start_i (startPtr),
        .gnt_o   (pickGnt),
        .idx_o   (pickIdx),
        .valid_o (pickValid)
    );

    assign m_gnt_o    = pickGnt;
    assign m_douta_o  = s_douta_i;
    assign m_rvalid_o = rdPend_q;
    assign s_ena_o    = pickValid;
    assign isRead     = (s_wea_o == '0);

    // Route the granted master's address, data and byte enables to the slave
    always_comb begin
        s_addra_o = '0;
        s_dina_o  = '0;
        s_wea_o   = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (pickGnt[i]) begin
                s_addra_o = m_addra_i[i*LEN_ADDR +: LEN_ADDR];
                s_dina_o  = m_dina_i[i*LEN_DATA +: LEN_DATA];
                s_wea_o   = m_wea_i[i*NB +: NB];
            end
        end
    end

    // Next state: lock tracking, pointer rotation and the pending-read flag
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lockCnt_d = lockCnt_q;
        rdPend_d  = '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        rrPtr_d   = rrPtr_q;
`endif
        if ((state_q == ARB_LOCKED) && !m_req_i[owner_q]) begin
            state_d   = ARB_IDLE;
            lockCnt_d = '0;
        end
        if (pickValid) begin
`ifndef SRAM_ARB_FIXED_PRIO_EN
            rrPtr_d = IW'((int'(pickIdx) + 1) % N_MASTER);
`endif
            rdPend_d = isRead ? pickGnt : '0;
            if (m_lock_i[pickIdx] && !(ownerHold && (lockCnt_q == CW'(LOCK_MAX)))) begin
                state_d   = ARB_LOCKED;
                owner_d   = pickIdx;
                lockCnt_d = ownerHold ? (lockCnt_q + CW'(1)) : CW'(1);
            end else begin
                state_d   = ARB_IDLE;
                lockCnt_d = '0;
            end
        end
    end

    // State registers; reset also drops any read still in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            owner_q   <= '0;
            lockCnt_q <= '0;
            rdPend_q  <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            rrPtr_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lockCnt_q <= lockCnt_d;
            rdPend_q  <= rdPend_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            rrPtr_q   <= rrPtr_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter with two masters and a behavioural SRAM slave.
// Expected read returns are queued when a cycle is driven and checked one cycle later.
module tb_sram_arbiter;

    typedef struct packed {
        logic [1:0]  mask;
        logic [63:0] data;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [1:0]   mReq;
    logic [1:0]   mLock;
    logic [127:0] mAddra;
    logic [127:0] mDina;
    logic [15:0]  mWea;
    logic [1:0]   mGnt;
    logic [63:0]  mDouta;
    logic [1:0]   mRvalid;
    logic [63:0]  sAddra;
    logic [63:0]  sDina;
    logic [63:0]  sDouta;
    logic         sEna;
    logic [7:0]   sWea;

    logic [63:0]  sramMem [0:255];
    logic [63:0]  refMem  [0:255];
    exp_t         expQ [$];
    int           testCount;
    int           failCount;

    sram_arbiter #(
        .LEN_ADDR(64),
        .LEN_DATA(64),
        .N_MASTER(2),
        .LOCK_MAX(8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m_req_i    (mReq),
        .m_lock_i   (mLock),
        .m_addra_i  (mAddra),
        .m_dina_i   (mDina),
        .m_wea_i    (mWea),
        .m_gnt_o    (mGnt),
        .m_douta_o  (mDouta),
        .m_rvalid_o (mRvalid),
        .s_addra_o  (sAddra),
        .s_dina_o   (sDina),
        .s_douta_i  (sDouta),
        .s_ena_o    (sEna),
        .s_wea_o    (sWea)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] memInit(input int i);
        return 64'hA5A5_0000_0000_0000 + (64'(i) * 64'h0001_0003);
    endfunction

    // Single-port SRAM slave with one cycle of read latency, preloaded on reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) sramMem[i] <= memInit(i);
        end else if (sEna) begin
            if (sWea == 8'h00) begin
                sDouta <= sramMem[sAddra[10:3]];
            end else begin
                for (int b = 0; b < 8; b++)
                    if (sWea[b]) sramMem[sAddra[10:3]][b*8 +: 8] <= sDina[b*8 +: 8];
            end
        end
    end

    // Give up if the run wanders off
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic refInit();
        for (int i = 0; i < 256; i++) refMem[i] = memInit(i);
    endtask

    // One bus cycle, entered just after a falling edge: check the returning read,
    // drive the new request pattern, check the grant, and queue the expected return
    task automatic applyStimulus(input string tag, input logic [1:0] req, input logic [1:0] lock,
                                 input logic [63:0] a0, input logic [63:0] a1,
                                 input logic [63:0] d0, input logic [63:0] d1,
                                 input logic [7:0] w0, input logic [7:0] w1,
                                 input logic [1:0] expGnt);
        exp_t        e;
        logic [63:0] wa;
        logic [63:0] wd;
        logic [7:0]  ww;
        e = '0;
        if (expQ.size() > 0) e = expQ.pop_front();
        checkOutput({tag, "/rvalid"}, 64'(mRvalid), 64'(e.mask));
        if (e.mask != 2'b00) checkOutput({tag, "/douta"}, mDouta, e.data);

        mReq   = req;
        mLock  = lock;
        mAddra = {a1, a0};
        mDina  = {d1, d0};
        mWea   = {w1, w0};
        #1;
        checkOutput({tag, "/gnt"}, 64'(mGnt), 64'(expGnt));
        checkOutput({tag, "/ena"}, 64'(sEna), 64'(|expGnt));

        e  = '0;
        wa = expGnt[1] ? a1 : a0;
        wd = expGnt[1] ? d1 : d0;
        ww = expGnt[1] ? w1 : w0;
        if (expGnt != 2'b00) begin
            checkOutput({tag, "/addr"}, sAddra, wa);
            checkOutput({tag, "/wea"}, 64'(sWea), 64'(ww));
            if (ww == 8'h00) begin
                e.mask = expGnt;
                e.data = refMem[wa[10:3]];
            end else begin
                for (int b = 0; b < 8; b++)
                    if (ww[b]) refMem[wa[10:3]][b*8 +: 8] = wd[b*8 +: 8];
            end
        end
        expQ.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(tag, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b00);
    endtask

    // Assert reset while a read is in flight and requests are still up
    task automatic resetPulse();
        rst = 1'b1;
        #1;
        checkOutput("rst/gnt", 64'(mGnt), 64'h0);
        checkOutput("rst/ena", 64'(sEna), 64'h0);
        checkOutput("rst/rvalid", 64'(mRvalid), 64'h0);
        checkOutput("rst/addr", sAddra, 64'h0);
        checkOutput("rst/wea", 64'(sWea), 64'h0);
        checkOutput("rst/dina", sDina, 64'h0);
        expQ.delete();
        refInit();
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        mReq = 2'b00;
        expQ.push_back('0);
    endtask

    // Main sequence
    initial begin
        testCount = 0;
        failCount = 0;
        rst    = 1'b1;
        mReq   = '0;
        mLock  = '0;
        mAddra = '0;
        mDina  = '0;
        mWea   = '0;
        refInit();
        @(negedge clk);
        checkOutput("init/gnt", 64'(mGnt), 64'h0);
        checkOutput("init/ena", 64'(sEna), 64'h0);
        checkOutput("init/rvalid", 64'(mRvalid), 64'h0);
        rst = 1'b0;
        expQ.push_back('0);

`ifdef SRAM_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 3; k++)
            applyStimulus("fixed", 2'b11, 2'b00, 64'(k * 8), 64'h40, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        applyStimulus("fixed1", 2'b10, 2'b00, 64'h0, 64'h40, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        applyStimulus("fixedwr", 2'b10, 2'b00, 64'h0, 64'h18, 64'h0, 64'hDEADBEEF, 8'h00, 8'hFF, 2'b10);
        applyStimulus("fixedrb", 2'b11, 2'b00, 64'h18, 64'h10, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        applyStimulus("fixedrd", 2'b11, 2'b00, 64'h20, 64'h10, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        resetPulse();
        applyStimulus("postrst", 2'b11, 2'b00, 64'h8, 64'h10, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        idleCycle("drain");
`else
        // Contention: both masters read, grants alternate
        applyStimulus("cont0", 2'b11, 2'b00, 64'h00, 64'h08, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        applyStimulus("cont1", 2'b11, 2'b00, 64'h20, 64'h08, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        applyStimulus("cont2", 2'b11, 2'b00, 64'h20, 64'h28, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        applyStimulus("cont3", 2'b11, 2'b00, 64'h40, 64'h28, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        idleCycle("idle0");

        // Single master: read, write, readback
        applyStimulus("m1rd", 2'b10, 2'b00, 64'h0, 64'h10, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        applyStimulus("m1wr", 2'b10, 2'b00, 64'h0, 64'h18, 64'h0, 64'hDEADBEEF, 8'h00, 8'hFF, 2'b10);
        applyStimulus("m1rb", 2'b10, 2'b00, 64'h0, 64'h18, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        idleCycle("idle1");

        // Lock: master0 holds for three locked accesses, then releases
        for (int k = 0; k < 3; k++)
            applyStimulus("lock", 2'b11, 2'b01, 64'(64'h60 + k * 8), 64'h30, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        applyStimulus("unlock", 2'b11, 2'b00, 64'h80, 64'h30, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        applyStimulus("afterlk", 2'b11, 2'b00, 64'h88, 64'h30, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);
        idleCycle("idle2");

        // Lock limit: forced release after the ninth locked access
        for (int k = 0; k < 10; k++)
            applyStimulus((k < 9) ? "locklim" : "forcedrel", 2'b11, 2'b01, 64'(64'h100 + k * 8), 64'h200,
                          64'h0, 64'h0, 8'h00, 8'h00, (k < 9) ? 2'b01 : 2'b10);
        idleCycle("idle3");

        // Locked owner drops req: the other master is granted in the same cycle
        applyStimulus("lockdrop0", 2'b01, 2'b01, 64'h48, 64'h0, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        applyStimulus("lockdrop1", 2'b10, 2'b00, 64'h0, 64'h50, 64'h0, 64'h0, 8'h00, 8'h00, 2'b10);

        // Reset in the middle of a read, then master0 wins first
        applyStimulus("prerst", 2'b11, 2'b00, 64'h58, 64'h68, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        resetPulse();
        applyStimulus("postrst", 2'b11, 2'b00, 64'h58, 64'h68, 64'h0, 64'h0, 8'h00, 8'h00, 2'b01);
        idleCycle("drain");
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter that shares one single-port synchronous SRAM-style slave (addra/dina/douta/ena/wea, 1-cycle read latency) among N requesters. It sits between masters such as the pipeline data port and a UART loader or debug port, and the data SRAM or board-IO slave. Masters use a req/gnt handshake. Read data is broadcast with a per-master valid. A bounded lock lets one master hold the slave for atomic read-modify-write sequences.

## Interface
- LEN_ADDR, 64, address width
- LEN_DATA, 64, data width (multiple of 8)
- N_MASTER, 2, number of requesters (2..4)
- LOCK_MAX, 8, max consecutive locked grants before forced release (≥1)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- m_req  in  N_MASTER  request, held until granted
- m_lock  in  N_MASTER  keep ownership after this access
- m_addra  in  N_MASTER×LEN_ADDR  per-master address
- m_dina  in  N_MASTER×LEN_DATA  per-master write data
- m_wea  in  N_MASTER×LEN_DATA/8  byte write enables; all-zero means read
- m_gnt  out  N_MASTER  one-hot grant; access accepted when req&gnt
- m_douta  out  LEN_DATA  read data, broadcast (= s_douta)
- m_rvalid  out  N_MASTER  read data valid for master i
- s_addra  out  LEN_ADDR  slave address
- s_dina  out  LEN_DATA  slave write data
- s_douta  in  LEN_DATA  slave read data, valid 1 cycle after ena
- s_ena  out  1  slave enable
- s_wea  out  LEN_DATA/8  slave byte enables

## Operation
- State: ARB_IDLE, ARB_LOCKED(owner). Registers: rr_ptr, owner, lock_cnt, rd_pend (one-hot).
- ARB_IDLE: grant the first requester at or after rr_ptr in circular index order. On acceptance, rr_ptr ← winner+1 mod N_MASTER.
- Accepted with m_lock=1 → ARB_LOCKED(winner), lock_cnt ← 1.
- ARB_LOCKED: only the owner may be granted, and others see gnt=0.
  - Owner accepted with lock=1 and lock_cnt<LOCK_MAX → stay, lock_cnt+1.
  - Owner accepted with lock=0 → ARB_IDLE.
  - Owner's req=0 in any cycle → ARB_IDLE, same cycle arbitrates normally (no dead cycle).
  - lock_cnt==LOCK_MAX → the owner's lock is ignored on its next acceptance. It returns to ARB_IDLE, and rr_ptr ← owner+1.
- Slave mux: s_ena = |(m_req&m_gnt); s_addra/s_dina/s_wea come from the granted master, else zero.
- Read accepted (wea==0) → rd_pend ← one-hot(winner) next cycle. m_rvalid = rd_pend. Writes produce no rvalid.
- Simultaneous events:
  - A new read and a returning read in the same cycle are both legal, because rd_pend is reloaded every cycle.
  - A request and a lock release in the same cycle resolve as stated above.
- No request → gnt=0, s_ena=0, rr_ptr unchanged.

## Timing
- m_gnt and the slave outputs are combinational from m_req and registered state; zero-cycle grant.
- Read latency: rvalid and data arrive 1 cycle after acceptance. Back-to-back accepts are allowed every cycle, at full throughput.
- Reset (async, any time): rr_ptr=0, state ARB_IDLE, lock_cnt=0, rd_pend=0.
  - While rst=1: m_gnt=0, s_ena=0, s_wea=0, m_rvalid=0, s_addra=0, s_dina=0.
  - An in-flight read is dropped and its rvalid is never asserted.
- Masters must hold addr/data/wea stable while req=1 and gnt=0.

## Configuration
- SRAM_ARB_FIXED_PRIO_EN defined:
  - Fixed priority, lowest index wins.
  - rr_ptr is removed, or held at 0.
  - Lock and LOCK_MAX still apply; a forced release simply re-arbitrates by fixed priority.
- Undefined: round-robin as specified.

## Structure
- Package sram_arb_pkg:
  - arb_state_e {ARB_IDLE, ARB_LOCKED}
  - function idx_w(N) for the master index width
  - MAX_MASTER=4 constant
- Sub-module rr_pick: combinational rotating priority encoder (req vector, start pointer → one-hot winner + index). It is instantiated once; under SRAM_ARB_FIXED_PRIO_EN its start pointer is tied to 0.

## Test plan
- Reset: assert rst mid-read with m_req=2'b11 → gnt=0, s_ena=0, rvalid=0 immediately. After release, first grant goes to master 0.
- Contention: m_req=2'b11 held for 4 cycles, both reads → gnt sequence 01,10,01,10; rvalid follows one cycle later with matching one-hot; m_douta equals SRAM contents at each address.
- Single master: master1 alone reads 0x10, writes 0x18 with wea=8'hFF data 0xDEADBEEF → gnt every cycle; rvalid[1] only after the read; a readback of 0x18 returns 0xDEADBEEF.
- Lock: master0 lock=1 for 3 accesses while m_req[1]=1 → master1 gnt=0 for those cycles. It is granted in the cycle after master0's lock=0 access.
- Lock limit (LOCK_MAX=8): master0 holds lock=1 continuously with master1 requesting → master1 granted after master0's 9th access.
- Fixed-priority build (macro defined), m_req=2'b11 for 3 cycles → gnt=01 every cycle; master1 granted only when m_req[0]=0.
